dmem_lat: RTL and testbench
===========================

Name: dmem_lat

Overview:
- Parametrised successor to the flat single-cycle instruction/data memory model used around Top.
- Byte-addressed, word-organised RAM with per-byte write enables and a configurable access latency.
- Exposes a valid/ready request channel and a one-cycle response pulse carrying read data and an error flag.
- Lets the pipeline and its bench exercise wait states, partial stores (SB/SH) and bad addresses; instantiated once for IMEM and once for DMEM.

Parameters:
ADDR_WIDTH, 32, request byte-address width
DATA_WIDTH, 32, word width; multiple of 8
DEPTH, 1024, number of words; power of 2
LATENCY, 1, cycles from acceptance edge to response; legal range 1..15

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_wen  input  1  1 = write, 0 = read
req_be  input  DATA_WIDTH/8  byte-lane write enables; ignored on reads
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  DATA_WIDTH  write data, lane i = bits [8i+7:8i]
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  DATA_WIDTH  read data; valid when rsp_valid=1
rsp_err  output  1  access error; valid when rsp_valid=1

Behaviour:
- Acceptance: occurs at a rising edge where req_valid=1, req_ready=1 and rst=0. Request fields are captured at that edge; the requester may change them afterwards.
- Single outstanding request. State is IDLE or BUSY, plus a down-counter cnt of width 4.
- Acceptance at edge k:
  - If LATENCY=1, the access executes at edge k itself.
  - Otherwise: state goes to BUSY, cnt loads LATENCY-2, cnt decrements each BUSY edge, and the access executes at the edge where BUSY and cnt=0.
  - In all cases the access executes at edge k+LATENCY-1.
- At the executing edge:
  - Memory is read or written.
  - rsp_valid, rsp_rdata and rsp_err are registered.
  - rsp_valid is 1 for exactly the one cycle after that edge, then returns to 0.
  - State returns to IDLE unless a new request is accepted at the same edge.
- req_ready (combinational):
  - 0 while rst=1.
  - Otherwise 1 when IDLE, or when BUSY with cnt=0 (completion and new acceptance share that edge).
  - Resulting throughput: LATENCY=1 gives one request per cycle; LATENCY=L≥2 gives one request per L-1 cycles.
- Address decode:
  - Word index = req_addr >> log2(DATA_WIDTH/8).
  - Error if the low log2(DATA_WIDTH/8) address bits are nonzero (misaligned) or the word index ≥ DEPTH.
- On error: rsp_err=1, rsp_rdata=0, memory unchanged.
- Write: lanes with req_be[i]=1 are updated and other lanes are kept. be=0 is a legal no-op write with rsp_err=0. rsp_rdata=0 on writes.
- Read: rsp_rdata is the full stored word; req_be is ignored.
- Ordering: accesses execute in acceptance order. A read accepted at or after the execute edge of an earlier write returns the written data.
- Between responses, rsp_rdata and rsp_err hold their last values. Consumers must qualify them with rsp_valid.
- Reset (synchronous):
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, cnt=0.
  - An in-flight request is dropped: no write, no response.
  - Memory array contents are NOT cleared; the array is uninitialised/X until written or preloaded via $readmemb on the mem array by the bench.
  - req_ready=1 from the first cycle after rst deasserts.
- Simultaneous req_valid with rst=1: not accepted.

Test Plan:
1. LATENCY=3: write 0xDEADBEEF to addr 0x10, be=4'hF, accepted at edge k → rsp_valid=1 only in the cycle after edge k+2, rsp_err=0. Then read 0x10 → rsp_rdata=0xDEADBEEF.
2. Byte enables: after test 1, write 0x11223344 to 0x10 with be=4'b0101 → subsequent read returns 0xDE22BE44. Write with be=4'b0000 → read still returns 0xDE22BE44, rsp_err=0.
3. Errors: write to 0x12 → rsp_err=1, word 0x10 unchanged. Read 0x1000 (index 1024, DEPTH=1024) → rsp_err=1, rsp_rdata=0. Read 0xFFC → rsp_err=0.
4. LATENCY=1 instance: req_valid held 1 for 8 consecutive reads of 0x0,0x4,…,0x1C preloaded with 1..8 → req_ready stays 1, rsp_valid=1 for 8 consecutive cycles, rsp_rdata=1..8 in order.
5. LATENCY=4, req_valid held high for 10 cycles → req_ready pattern 1,0,0,1,0,0,1,…. Exactly one acceptance per 3 cycles; responses 4 cycles after each acceptance edge.
6. LATENCY=4: accept write 0xCAFEF00D to 0x20 over prior 0x0, pulse rst for one cycle 2 edges later → no rsp_valid, read of 0x20 returns 0x0, req_ready=0 during rst and 1 the cycle after.

Source files
------------

// File: rtl/dmem_lat.sv
// Byte-addressed, word-organised RAM with per-lane write enables, a valid/ready
// request channel and a fixed access latency of LATENCY cycles (1..15).
module dmem_lat #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wen,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF   = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, state_next;
    logic [3:0] cnt, cnt_next;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  accept;
    logic                  exec;
    logic                  x_wen;
    logic [BYTES-1:0]      x_be;
    logic [ADDR_WIDTH-1:0] x_addr;
    logic [DATA_WIDTH-1:0] x_wdata;

    logic                  misaligned;
    logic                  out_of_range;
    logic                  err;
    logic [IDX_W-1:0]      idx;
    logic [ADDR_WIDTH:0]   word_num;

    // A busy block can take the next request on the same edge its access completes.
    assign req_ready = !rst && (state == IDLE || cnt == 4'd0);
    assign accept    = req_valid && req_ready;

    generate
        if (LATENCY == 1) begin : g_direct
            assign x_wen   = req_wen;
            assign x_be    = req_be;
            assign x_addr  = req_addr;
            assign x_wdata = req_wdata;
            assign exec    = accept;
        end else begin : g_capture
            always_ff @(posedge clk) begin
                if (accept) begin
                    x_wen   <= req_wen;
                    x_be    <= req_be;
                    x_addr  <= req_addr;
                    x_wdata <= req_wdata;
                end
            end
            assign exec = !rst && state == BUSY && cnt == 4'd0;
        end
    endgenerate

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (state == BUSY && cnt != 4'd0) begin
            cnt_next = cnt - 4'd1;
        end
        if (exec) begin
            state_next = IDLE;
        end
        if (accept && LATENCY > 1) begin
            state_next = BUSY;
            cnt_next   = CNT_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Word index is compared one bit wider so DEPTH itself never truncates.
    always_comb begin
        misaligned   = |(x_addr & ADDR_WIDTH'(BYTES - 1));
        word_num     = {1'b0, x_addr >> OFF};
        out_of_range = word_num >= (ADDR_WIDTH + 1)'(DEPTH);
        err          = misaligned || out_of_range;
        idx          = x_addr[OFF +: IDX_W];
    end

    always_ff @(posedge clk) begin
        if (exec && x_wen && !err) begin
            for (int i = 0; i < BYTES; i++) begin
                if (x_be[i]) begin
                    mem[idx][8*i +: 8] <= x_wdata[8*i +: 8];
                end
            end
        end
    end

    // Data and error hold between responses; only rsp_valid pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= exec;
            if (exec) begin
                rsp_err   <= err;
                rsp_rdata <= (err || x_wen) ? '0 : mem[idx];
            end
        end
    end

endmodule

// File: tb/tb_dmem_lat.sv
// Bench for dmem_lat: three instances (LATENCY 3, 1, 4) checked by directed
// vectors, hand sequences and a random run against a transaction-level model.
module tb_dmem_lat;

    logic        clk = 1'b0;
    logic        rst       [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_wen   [3];
    logic [3:0]  req_be    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic        rsp_valid [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_lat #(
            .ADDR_WIDTH(32),
            .DATA_WIDTH(32),
            .DEPTH(1024),
            .LATENCY((g == 0) ? 3 : ((g == 1) ? 1 : 4))
        ) dut (
            .clk(clk),
            .rst(rst[g]),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_wen(req_wen[g]),
            .req_be(req_be[g]),
            .req_addr(req_addr[g]),
            .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_err(rsp_err[g])
        );
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 3 : ((i == 1) ? 1 : 4);
    endfunction

    int total_checks  = 0;
    int passed_checks = 0;

    task automatic check_output(input string name, input int inst,
                                input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) passed_checks++;
        else $display("[TB] FAIL %s (dut %0d): got %h, expected %h", name, inst, act, exp);
    endtask

    // Transaction-level model: each accepted request is due at a fixed edge,
    // acceptance is allowed once per period, and reset discards what is pending.
    int          edge_no = 0;
    int          next_free [3];
    bit          started   [3];
    bit          pend_v    [3];
    int          pend_due  [3];
    bit          pend_wen  [3];
    bit [3:0]    pend_be   [3];
    bit [31:0]   pend_addr [3];
    bit [31:0]   pend_wdata[3];
    bit          exp_valid [3];
    bit [31:0]   exp_rdata [3];
    bit [31:0]   exp_mask  [3];
    bit          exp_err   [3];
    bit [31:0]   mmem  [3][1024];
    bit [31:0]   mmask [3][1024];

    task automatic model_exec(input int i);
        int idx;
        bit bad;
        idx = int'(pend_addr[i] >> 2);
        bad = (pend_addr[i][1:0] != 2'b00) || (pend_addr[i] >= 32'h1000);
        exp_valid[i] = 1'b1;
        exp_err[i]   = bad;
        exp_mask[i]  = 32'hFFFF_FFFF;
        exp_rdata[i] = 32'h0;
        if (!bad && pend_wen[i]) begin
            for (int b = 0; b < 4; b++) begin
                if (pend_be[i][b]) begin
                    mmem[i][idx][8*b +: 8]  = pend_wdata[i][8*b +: 8];
                    mmask[i][idx][8*b +: 8] = 8'hFF;
                end
            end
        end else if (!bad) begin
            exp_rdata[i] = mmem[i][idx];
            exp_mask[i]  = mmask[i][idx];
        end
        pend_v[i] = 1'b0;
    endtask

    always @(posedge clk) begin
        edge_no++;
        for (int i = 0; i < 3; i++) begin
            exp_valid[i] = 1'b0;
            if (rst[i]) begin
                started[i]   = 1'b1;
                pend_v[i]    = 1'b0;
                exp_rdata[i] = 32'h0;
                exp_mask[i]  = 32'hFFFF_FFFF;
                exp_err[i]   = 1'b0;
                next_free[i] = edge_no + 1;
            end else if (started[i]) begin
                if (pend_v[i] && pend_due[i] == edge_no) model_exec(i);
                if (req_valid[i] && edge_no >= next_free[i]) begin
                    pend_v[i]     = 1'b1;
                    pend_due[i]   = edge_no + lat_of(i) - 1;
                    pend_wen[i]   = req_wen[i];
                    pend_be[i]    = req_be[i];
                    pend_addr[i]  = req_addr[i];
                    pend_wdata[i] = req_wdata[i];
                    next_free[i]  = edge_no + ((lat_of(i) == 1) ? 1 : lat_of(i) - 1);
                    if (pend_due[i] == edge_no) model_exec(i);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (started[i]) begin
                check_output("req_ready", i, 32'(req_ready[i]),
                             32'(!rst[i] && (edge_no + 1 >= next_free[i])));
                check_output("rsp_valid", i, 32'(rsp_valid[i]), 32'(exp_valid[i]));
                check_output("rsp_err", i, 32'(rsp_err[i]), 32'(exp_err[i]));
                check_output("rsp_rdata", i, rsp_rdata[i] & exp_mask[i],
                             exp_rdata[i] & exp_mask[i]);
            end
        end
    end

    // One request, held until accepted, then wait for its response pulse.
    task automatic apply_stimulus(input int i, input bit wen, input bit [3:0] be,
                                  input bit [31:0] addr, input bit [31:0] wdata,
                                  output bit got, output bit [31:0] rdata,
                                  output bit err, output int lat);
        bit rdy;
        int n;
        got = 1'b0; rdata = 32'h0; err = 1'b0; lat = 0;
        @(posedge clk); #1;
        req_wen[i] = wen; req_be[i] = be; req_addr[i] = addr; req_wdata[i] = wdata;
        req_valid[i] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            rdy = req_ready[i];
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 50);
        req_valid[i] = 1'b0;
        if (!rdy) begin
            check_output("accept_timeout", i, 32'd0, 32'd1);
            return;
        end
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (rsp_valid[i]) begin
                got = 1'b1; rdata = rsp_rdata[i]; err = rsp_err[i]; lat = c;
                break;
            end
        end
    endtask

    typedef struct {
        bit        wen;
        bit [3:0]  be;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit        exp_err;
        bit [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[13];

    initial begin
        bit        got, err;
        bit [31:0] rdata;
        int        lat, acc;
        bit        exp_rdy, exp_rv;

        vecs[0]  = '{1'b1, 4'hF, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 4'h0, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 4'h5, 32'h10,   32'h11223344, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 4'hA, 32'h10,   32'h0,        1'b0, 32'hDE22BE44};
        vecs[4]  = '{1'b1, 4'h0, 32'h10,   32'hFFFFFFFF, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 4'h0, 32'h10,   32'h0,        1'b0, 32'hDE22BE44};
        vecs[6]  = '{1'b1, 4'hF, 32'h12,   32'h0,        1'b1, 32'h0};
        vecs[7]  = '{1'b0, 4'hF, 32'h10,   32'h0,        1'b0, 32'hDE22BE44};
        vecs[8]  = '{1'b0, 4'h0, 32'h1000, 32'h0,        1'b1, 32'h0};
        vecs[9]  = '{1'b1, 4'hF, 32'hFFC,  32'h0BADF00D, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 4'h0, 32'hFFC,  32'h0,        1'b0, 32'h0BADF00D};
        vecs[11] = '{1'b0, 4'hF, 32'h11,   32'h0,        1'b1, 32'h0};
        vecs[12] = '{1'b1, 4'hF, 32'h1004, 32'h12345678, 1'b1, 32'h0};

        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; req_valid[i] = 1'b0; req_wen[i] = 1'b0;
            req_be[i] = 4'h0; req_addr[i] = 32'h0; req_wdata[i] = 32'h0;
            started[i] = 1'b0; pend_v[i] = 1'b0; next_free[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;

        $display("[TB] directed vectors on LATENCY=3");
        for (int v = 0; v < 13; v++) begin
            apply_stimulus(0, vecs[v].wen, vecs[v].be, vecs[v].addr, vecs[v].wdata,
                           got, rdata, err, lat);
            check_output($sformatf("vec%0d_got", v), 0, 32'(got), 32'd1);
            check_output($sformatf("vec%0d_err", v), 0, 32'(err), 32'(vecs[v].exp_err));
            check_output($sformatf("vec%0d_rdata", v), 0, rdata, vecs[v].exp_rdata);
            check_output($sformatf("vec%0d_latency", v), 0, 32'(lat), 32'd3);
        end

        $display("[TB] back-to-back reads on LATENCY=1");
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(1, 1'b1, 4'hF, 32'(4 * k), 32'(k + 1), got, rdata, err, lat);
            check_output("preload_latency", 1, 32'(lat), 32'd1);
        end
        @(posedge clk); #1;
        req_wen[1] = 1'b0; req_addr[1] = 32'h0; req_valid[1] = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check_output("stream_ready", 1, 32'(req_ready[1]), 32'd1);
            if (j > 0) begin
                check_output("stream_valid", 1, 32'(rsp_valid[1]), 32'd1);
                check_output("stream_rdata", 1, rsp_rdata[1], 32'(j));
            end
            @(posedge clk); #1;
            if (j < 7) req_addr[1] = 32'(4 * (j + 1));
            else req_valid[1] = 1'b0;
        end
        @(negedge clk);
        check_output("stream_valid", 1, 32'(rsp_valid[1]), 32'd1);
        check_output("stream_rdata", 1, rsp_rdata[1], 32'd8);
        @(negedge clk);
        check_output("stream_end_valid", 1, 32'(rsp_valid[1]), 32'd0);

        $display("[TB] held request throughput on LATENCY=4");
        @(posedge clk); #1;
        req_wen[2] = 1'b0; req_addr[2] = 32'h0; req_valid[2] = 1'b1;
        acc = 0;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            exp_rdy = (j <= 12) ? ((j % 3) == 0) : 1'b1;
            exp_rv  = (j >= 4) && (j <= 13) && (((j - 4) % 3) == 0);
            check_output($sformatf("tput_ready_c%0d", j), 2, 32'(req_ready[2]), 32'(exp_rdy));
            check_output($sformatf("tput_rsp_c%0d", j), 2, 32'(rsp_valid[2]), 32'(exp_rv));
            if (req_ready[2] && req_valid[2]) acc++;
            @(posedge clk); #1;
            if (j == 9) req_valid[2] = 1'b0;
        end
        check_output("tput_accepts", 2, 32'(acc), 32'd4);

        $display("[TB] reset drops in-flight write on LATENCY=4");
        apply_stimulus(2, 1'b1, 4'hF, 32'h20, 32'h0, got, rdata, err, lat);
        check_output("pre_write_latency", 2, 32'(lat), 32'd4);
        @(posedge clk); #1;
        req_wen[2] = 1'b1; req_be[2] = 4'hF; req_addr[2] = 32'h20;
        req_wdata[2] = 32'hCAFEF00D; req_valid[2] = 1'b1;
        @(negedge clk);
        check_output("drop_accept_ready", 2, 32'(req_ready[2]), 32'd1);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        @(negedge clk);
        check_output("drop_rsp_k", 2, 32'(rsp_valid[2]), 32'd0);
        @(posedge clk); #1;
        rst[2] = 1'b1;
        @(negedge clk);
        check_output("drop_ready_in_rst", 2, 32'(req_ready[2]), 32'd0);
        @(posedge clk); #1;
        rst[2] = 1'b0;
        @(negedge clk);
        check_output("drop_ready_after_rst", 2, 32'(req_ready[2]), 32'd1);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check_output("drop_no_rsp", 2, 32'(rsp_valid[2]), 32'd0);
        end
        apply_stimulus(2, 1'b0, 4'h0, 32'h20, 32'h0, got, rdata, err, lat);
        check_output("drop_read_rdata", 2, rdata, 32'h0);
        check_output("drop_read_err", 2, 32'(err), 32'd0);

        $display("[TB] random traffic on all instances");
        repeat (400) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                int r;
                r = int'($urandom_range(0, 9));
                rst[i]       = ($urandom_range(0, 63) == 0);
                req_valid[i] = 1'($urandom_range(0, 1));
                req_wen[i]   = 1'($urandom_range(0, 1));
                req_be[i]    = 4'($urandom_range(0, 15));
                req_wdata[i] = $urandom;
                if (r < 7)       req_addr[i] = 32'($urandom_range(0, 15) * 4);
                else if (r == 7) req_addr[i] = 32'($urandom_range(0, 63));
                else if (r == 8) req_addr[i] = 32'h1000 + 32'($urandom_range(0, 3) * 4);
                else             req_addr[i] = 32'hFFC;
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b0; req_valid[i] = 1'b0;
        end
        repeat (8) @(posedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
